// File: rtl/tdm_demux_1_n_if.sv
// rtl/tdm_demux_1_n_if.sv - lane stream in / parallel frame out bundle for tdm_demux_1_n
// Ports:
//   din, din_valid, frame_sync : serial beat stream toward the demux
//   dout, dout_valid           : last complete frame and its one-cycle update pulse
//   slot, locked, sync_err     : framing status
// The master modport drives the stream. The slave modport is the demux.
interface tdm_demux_1_n_if #(
    parameter int N = 4,
    parameter int W = 1
);
    localparam int SEL_W = $clog2(N);

    logic [W-1:0]     din;
    logic             din_valid;
    logic             frame_sync;
    logic [N*W-1:0]   dout;
    logic             dout_valid;
    logic [SEL_W-1:0] slot;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  dout, dout_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, dout_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_1_n.sv
// rtl/tdm_demux_1_n.sv - 1:N time-division demultiplexer with frame_sync locking
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : tdm_demux_1_n_if.slave
//         din/din_valid/frame_sync in; dout/dout_valid/slot/locked/sync_err out
// Lane k of dout (dout[k*W +: W]) holds slot k of the last complete frame.
// All outputs come straight from registers.
module tdm_demux_1_n #(
    parameter int N = 4,
    parameter int W = 1
) (
    input  logic            clk,
    input  logic            rst,
    tdm_demux_1_n_if.slave  bus
);
    localparam int               SEL_W     = $clog2(N);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [N*W-1:0]   stage_q, stage_d;
    logic [N*W-1:0]   dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             err_q, err_d;

    // Staging with the current beat merged into lane[slot]
    logic [N*W-1:0]   written;
    // Fresh frame holding only the current beat in lane 0
    logic [N*W-1:0]   first_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            stage_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            stage_q <= stage_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        stage_d    = stage_q;
        dout_d     = dout_q;
        dv_d       = 1'b0;
        err_d      = 1'b0;
        written    = stage_q;
        written[int'(slot_q)*W +: W] = bus.din;
        first_beat = '0;
        first_beat[W-1:0] = bus.din;

        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    // Non-sync beats are dropped silently while hunting
                    if (bus.frame_sync) begin
                        stage_d = first_beat;
                        slot_d  = SEL_W'(1);
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (slot_q != '0) begin
                        if (!bus.frame_sync) begin
                            stage_d = written;
                            if (slot_q == LAST_SLOT) begin
                                slot_d = '0;
                                dout_d = written;
                                dv_d   = 1'b1;
                            end else begin
                                slot_d = slot_q + SEL_W'(1);
                            end
                        end else begin
                            // Early sync: abandon the partial frame and restart on this beat
                            err_d   = 1'b1;
                            stage_d = first_beat;
                            slot_d  = SEL_W'(1);
                        end
                    end else begin
                        if (bus.frame_sync) begin
                            stage_d = first_beat;
                            slot_d  = SEL_W'(1);
                        end else begin
                            // Missing sync: alignment is lost, drop back to hunting
                            err_d   = 1'b1;
                            stage_d = '0;
                            slot_d  = '0;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.slot       = slot_q;
    assign bus.locked     = (state_q == LOCK);
    assign bus.sync_err   = err_q;
endmodule
